portb_arbiter: RTL and testbench
================================

Name: portb_arbiter

Overview:
- Shares dual-port RAM port B (10-bit address, 16-bit data) between several requesters, e.g. a display scanner and a debug/program loader. Port A stays dedicated to the CPU.
- Round-robin arbitration. One transaction in flight at a time.
- Drives the RAM port B address, data and write-enable pins. Captures the registered read data and returns it with a per-requester ack pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 10, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  clock; RAM is on the same clock edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per requester; level, held until ack.
- we  in  NUM_REQ  1 = write, 0 = read; sampled at grant.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened write data, same packing.
- ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read.
- busy  out  1  high while a transaction is in ACCESS or RESP.
- owner  out  3  index of the current or last granted requester.
- ram_en_b  out  1  RAM port B write enable.
- ram_addr_b  out  ADDR_W  RAM port B address.
- ram_data_b  out  DATA_W  RAM port B write data.
- ram_out_b  in  DATA_W  RAM port B read data; registered, one cycle after address.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE; ack=0; rdata=0; busy=0; owner=0; ram_en_b=0; ram_addr_b=0; ram_data_b=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - No req: hold all outputs; ram_en_b=0.
  - Otherwise pick the first asserted req scanning from last_grant+1, wrapping modulo NUM_REQ.
  - Register owner, the winner's we/addr/wdata into ram_addr_b/ram_data_b/ram_en_b, and last_grant.
  - Go to ACCESS.
- ACCESS: one cycle. RAM sees the address; ram_en_b=we for this cycle only. Go to RESP.
- RESP:
  - ram_en_b=0.
  - Read: rdata<=ram_out_b.
  - Pulse ack[owner] in the cycle after RESP is entered, together with the rdata update. Then return to IDLE.
  - Write: rdata unchanged.
- Latency and throughput:
  - req rise in IDLE to ack is 3 cycles.
  - Throughput is 1 transaction per 3 cycles.
  - A requester may re-arbitrate in the cycle after its ack.
- req deasserted mid-transaction: the transaction still completes and ack still pulses. Inputs are not re-sampled after grant.
- Simultaneous req from all requesters: strict rotation, each served once per NUM_REQ transactions; no starvation.
- Writes and reads from different requesters never overlap; the port B write enable is high for at most 1 cycle per transaction.
- reset asserted in any state: return to IDLE next edge, with the reset values. An in-flight ack is suppressed and no write is issued.
- owner is indexed only up to NUM_REQ-1; unused upper bits are 0.

Optional Feature:
- PORTB_ARB_STATS_EN
- Defined:
  - Adds output grant_cnt, NUM_REQ*16 bits.
  - One 16-bit counter per requester, incremented on that requester's ack and saturating at 16'hFFFF.
  - Adds input stats_clr; a 1-cycle pulse zeroes all counters, and clr wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package portb_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default ADDR_W/DATA_W constants;
  - the OWNER_W=3 constant.
- One combinational sub-module, rr_pick: inputs req and last_grant, outputs grant_valid and grant_idx. It is reusable for the later bus arbiter.

Test Plan:
- After reset, req=2'b01, we=0, addr0=10'h005, RAM[5]=16'hBEEF -> ack=2'b01 on cycle 3, rdata=16'hBEEF, ram_en_b never high.
- req=2'b10, we=1, addr1=10'h3FF, wdata1=16'h1234 -> ram_en_b high exactly 1 cycle with ram_addr_b=10'h3FF; a later read of 10'h3FF returns 16'h1234.
- Both req held high for 6 transactions -> ack order 0,1,0,1,0,1, one ack every 3 cycles.
- req0 dropped in the ACCESS cycle -> ack0 still pulses; no new grant until req is reasserted.
- reset asserted in ACCESS of a write -> no ack; state IDLE next cycle; all outputs at reset values; next grant goes to requester 0.
- With PORTB_ARB_STATS_EN: 3 acks to requester 1 -> grant_cnt[31:16]=3; stats_clr pulse -> 0; preloaded at 16'hFFFF plus 1 ack -> stays 16'hFFFF.

Source files
------------

// File: rtl/portb_arb_pkg.sv
// portb_arb_pkg: shared types and constants for the RAM port B arbiter.
// Optional build macro: PORTB_ARB_STATS_EN (per-requester ack counters).
package portb_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int OWNER_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/portb_arbiter_if.sv
// portb_arbiter_if: requester-side and RAM-side signals of the arbiter.
// Optional build macro: PORTB_ARB_STATS_EN (counter ports live on the top).
interface portb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = portb_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W  = portb_arb_pkg::DATA_W_DEF
) ();
  import portb_arb_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [OWNER_W-1:0]        owner;
  logic                      ram_en_b;
  logic [ADDR_W-1:0]         ram_addr_b;
  logic [DATA_W-1:0]         ram_data_b;
  logic [DATA_W-1:0]         ram_out_b;

  modport master (
    output req, we, addr, wdata, ram_out_b,
    input  ack, rdata, busy, owner,
    input  ram_en_b, ram_addr_b, ram_data_b
  );

  modport slave (
    input  req, we, addr, wdata, ram_out_b,
    output ack, rdata, busy, owner,
    output ram_en_b, ram_addr_b, ram_data_b
  );

endinterface

// File: rtl/portb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, scans from last_grant+1.
// Optional build macro: PORTB_ARB_STATS_EN (not used here).
module rr_pick
  import portb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_grant,
  output logic               grant_valid,
  output logic [OWNER_W-1:0] grant_idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          grant_valid = 1'b1;
          grant_idx   = OWNER_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/portb_arbiter.sv
// portb_arbiter: round-robin sharing of dual-port RAM port B.
// Optional build macro: PORTB_ARB_STATS_EN adds stats_clr / grant_cnt.
module portb_arbiter
  import portb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic            clk,
  input logic            reset,
  portb_arbiter_if.slave bus
`ifdef PORTB_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  state_e              state_q, state_d;
  logic [OWNER_W-1:0]  owner_q, last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                en_q, we_q;

  logic                gv;
  logic [OWNER_W-1:0]  gi;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                load, finish, busy;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req         (bus.req),
    .last_grant  (last_q),
    .grant_valid (gv),
    .grant_idx   (gi)
  );

  // Mux the winner's request fields.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gi == OWNER_W'(i)) begin
        sel_we   = bus.we[i];
        sel_addr = bus.addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = gv ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant load, completion strobe, busy flag.
  always_comb begin
    load   = 1'b0;
    finish = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      IDLE:    load   = gv;
      ACCESS:  busy   = 1'b1;
      RESP: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: ;
    endcase
  end

  // One-hot ack for the current owner.
  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = finish && (owner_q == OWNER_W'(i));
    end
  end

  // Grant capture, write strobe, read capture and ack pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      last_q  <= OWNER_W'(NUM_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      ack_q <= ack_d;
      en_q  <= load && sel_we;
      if (load) begin
        owner_q <= gi;
        last_q  <= gi;
        addr_q  <= sel_addr;
        data_q  <= sel_data;
        we_q    <= sel_we;
      end
      if (finish && !we_q) begin
        rdata_q <= bus.ram_out_b;
      end
    end
  end

  // Reset on the ACCESS edge must not let the write reach the RAM.
  assign bus.ram_en_b   = en_q && !reset;
  assign bus.ram_addr_b = addr_q;
  assign bus.ram_data_b = data_q;
  assign bus.ack        = ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy;
  assign bus.owner      = owner_q;

`ifdef PORTB_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Saturating per-requester ack counters; clear beats increment.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (ack_q[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_portb_arbiter.sv
// tb_portb_arbiter: directed + random checks of portb_arbiter with a RAM model.
// Optional build macro: PORTB_ARB_STATS_EN enables counter checks.
module tb_portb_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  portb_arbiter_if #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) bus ();

`ifdef PORTB_ARB_STATS_EN
  logic          stats_clr;
  logic [N*16-1:0] grant_cnt;
`endif

  portb_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PORTB_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 16'hBEEF;
    return DW'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Synchronous RAM: write-enable plus registered read-before-write output.
  logic [DW-1:0] mem [1<<AW];
  bit            mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (bus.ram_en_b === 1'b1) mem[bus.ram_addr_b] <= bus.ram_data_b;
      bus.ram_out_b <= mem[bus.ram_addr_b];
    end
  end

  // Transaction-level reference state.
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] ref_rdata;
  int            ref_last;
  int            ref_cnt [N];

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cyc, output int enc,
                          output logic [AW-1:0] ea,
                          output logic [DW-1:0] ed);
    cyc = 0;
    enc = 0;
    ea  = '0;
    ed  = '0;
    do begin
      step();
      cyc++;
      if (bus.ram_en_b === 1'b1) begin
        enc++;
        ea = bus.ram_addr_b;
        ed = bus.ram_data_b;
      end
    end while (bus.ack === '0 && cyc < 12);
  endtask

  task automatic txn(input int r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    int cyc, enc, exp_w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bus.req = '0;
    bus.req[r] = 1'b1;
    bus.we[r] = w;
    bus.addr[r*AW +: AW] = a;
    bus.wdata[r*DW +: DW] = d;
    exp_w = pick(bus.req, ref_last);
    wait_ack(cyc, enc, ea, ed);
    bus.req = '0;
    chk("latency", cyc, 3);
    chk("ack", bus.ack, 32'(1) << exp_w);
    chk("owner", bus.owner, exp_w);
    chk("we_pulses", enc, w ? 1 : 0);
    if (w) begin
      chk("waddr", ea, a);
      chk("wdata", ed, d);
      ref_mem[a] = d;
    end else begin
      ref_rdata = ref_mem[a];
    end
    chk("rdata", bus.rdata, ref_rdata);
    ref_last = exp_w;
    ref_cnt[exp_w]++;
    step();
    chk("ack_clear", bus.ack, 0);
  endtask

  initial begin
    int cyc, enc, exp_w, n;
    logic [AW-1:0] ea, a0, a1;
    logic [DW-1:0] ed;

    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    ref_last  = N - 1;
    ref_rdata = '0;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef PORTB_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_en", bus.ram_en_b, 0);
    chk("rst_addr", bus.ram_addr_b, 0);
    chk("rst_data", bus.ram_data_b, 0);

    txn(0, 1'b0, 10'h005, 16'h0000);
    chk("beef", bus.rdata, 16'hBEEF);
    txn(1, 1'b1, 10'h3FF, 16'h1234);
    txn(0, 1'b0, 10'h3FF, 16'h0000);
    chk("rb_3ff", bus.rdata, 16'h1234);

    for (int t = 0; t < 10; t++) begin
      txn($urandom_range(0, N-1), 1'($urandom_range(0, 1)),
          10'h100 + 10'($urandom_range(0, 7)), 16'($urandom));
    end

    txn(1, 1'b0, 10'h020, 16'h0000);
    a0 = 10'h101;
    a1 = 10'h102;
    bus.we = '0;
    bus.addr[0*AW +: AW] = a0;
    bus.addr[1*AW +: AW] = a1;
    bus.req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_w = pick(2'b11, ref_last);
      wait_ack(cyc, enc, ea, ed);
      chk("rr_interval", cyc, 3);
      chk("rr_ack", bus.ack, 32'(1) << (t % 2));
      chk("rr_model", bus.ack, 32'(1) << exp_w);
      chk("rr_rdata", bus.rdata, ref_mem[exp_w == 0 ? a0 : a1]);
      chk("rr_no_we", enc, 0);
      ref_last = exp_w;
      ref_cnt[exp_w]++;
    end
    bus.req = '0;
    step();
    chk("rr_done", bus.ack, 0);

    bus.we[0] = 1'b0;
    bus.addr[0*AW +: AW] = 10'h104;
    bus.req = 2'b01;
    exp_w = pick(bus.req, ref_last);
    step();
    chk("drop_busy", bus.busy, 1);
    bus.req = '0;
    n = 1;
    do begin
      step();
      n++;
    end while (bus.ack === '0 && n < 12);
    chk("drop_lat", n, 3);
    chk("drop_ack", bus.ack, 32'(1) << exp_w);
    chk("drop_rdata", bus.rdata, ref_mem[10'h104]);
    ref_last = exp_w;
    ref_cnt[exp_w]++;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("drop_idle", {bus.ack, bus.busy}, 0);
    end

    bus.we[1] = 1'b1;
    bus.addr[1*AW +: AW] = 10'h010;
    bus.wdata[1*DW +: DW] = ~ref_mem[10'h010];
    bus.req = 2'b10;
    step();
    chk("pre_rst_en", bus.ram_en_b, 1);
    reset = 1'b1;
    #1;
    chk("rst_gate_en", bus.ram_en_b, 0);
    step();
    reset = 1'b0;
    bus.req = '0;
    ref_last = N - 1;
    ref_rdata = '0;
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    chk("mrst_ack", bus.ack, 0);
    chk("mrst_rdata", bus.rdata, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_owner", bus.owner, 0);
    chk("mrst_en", bus.ram_en_b, 0);
    chk("mrst_addr", bus.ram_addr_b, 0);
    chk("mrst_data", bus.ram_data_b, 0);
    for (int t = 0; t < 3; t++) begin
      step();
      chk("mrst_no_ack", bus.ack, 0);
    end
    bus.we = '0;
    bus.addr[0*AW +: AW] = 10'h010;
    bus.addr[1*AW +: AW] = 10'h020;
    bus.req = 2'b11;
    exp_w = pick(bus.req, ref_last);
    wait_ack(cyc, enc, ea, ed);
    bus.req = '0;
    chk("post_rst_ack", bus.ack, 2'b01);
    chk("post_rst_model", bus.ack, 32'(1) << exp_w);
    chk("no_write", bus.rdata, ref_mem[10'h010]);
    ref_last = exp_w;
    ref_cnt[exp_w]++;
    step();

`ifdef PORTB_ARB_STATS_EN
    for (int t = 0; t < 3; t++) txn(1, 1'b0, 10'h030, 16'h0000);
    step();
    for (int i = 0; i < N; i++) begin
      chk("cnt", grant_cnt[i*16 +: 16], ref_cnt[i]);
    end
    chk("cnt1_is3", grant_cnt[31:16], 3);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("cnt_clr", grant_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
